// File: rtl/mips_decode_pkg.sv
// Shared opcode, immediate-kind and extender-select encodings for the mips32 decode path.
package mips_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Extender mux select, shared with the extender/mux bench.
  localparam logic EXT_SIGN = 1'b0;
  localparam logic EXT_ZERO = 1'b1;

  typedef enum logic [1:0] {
    KIND_NONE  = 2'b00,
    KIND_ARITH = 2'b01,
    KIND_LOGIC = 2'b10,
    KIND_LUI   = 2'b11
  } imm_kind_e;

  // imm16 is not stored separately: it is {rd, shamt, funct}.
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
    logic       ext_select;
    imm_kind_e  imm_kind;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/imm_ext_decoder.sv
// Combinational opcode -> extension mode decode feeding the stage output register.
module imm_ext_decoder
  import mips_decode_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       ext_select,
  output imm_kind_e  imm_kind,
  output logic       illegal
);

  always_comb begin
    ext_select = EXT_SIGN;
    imm_kind   = KIND_NONE;
    illegal    = 1'b0;
    case (opcode)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_BEQ, OP_BNE, OP_LW, OP_SW: imm_kind = KIND_ARITH;
      OP_ANDI, OP_ORI, OP_XORI: begin
        ext_select = EXT_ZERO;
        imm_kind   = KIND_LOGIC;
      end
      OP_LUI: begin
        ext_select = EXT_ZERO;
        imm_kind   = KIND_LUI;
      end
      OP_RTYPE, OP_J, OP_JAL: ;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered instruction decode stage ahead of the immediate extender/mux.
// Optional IMM_DECODE_STATS_EN adds saturating accepted/illegal counters.
module imm_decode_stage
  import mips_decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [IMM_W-1:0]  imm16,
  output logic              ext_select,
  output logic [1:0]        imm_kind,
  output logic              illegal
`ifdef IMM_DECODE_STATS_EN
  ,
  output logic [31:0]       stat_count,
  output logic [15:0]       stat_illegal
`endif
);

  dec_t      d, q;
  logic      accept;
  logic      dec_ext, dec_ill;
  imm_kind_e dec_kind;

  imm_ext_decoder u_dec (
    .opcode    (instr[31:26]),
    .ext_select(dec_ext),
    .imm_kind  (dec_kind),
    .illegal   (dec_ill)
  );

  assign in_ready = !out_valid || out_ready;
  // flush still lets in_ready evaluate but the word is dropped
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    d            = '0;
    d.opcode     = instr[31:26];
    d.rs         = instr[25:21];
    d.rt         = instr[20:16];
    d.rd         = instr[15:11];
    d.shamt      = instr[10:6];
    d.funct      = instr[5:0];
    d.ext_select = dec_ext;
    d.imm_kind   = dec_kind;
    d.illegal    = dec_ill;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (accept) q <= d;
    end
  end

  assign opcode     = q.opcode;
  assign rs         = q.rs;
  assign rt         = q.rt;
  assign rd         = q.rd;
  assign shamt      = q.shamt;
  assign funct      = q.funct;
  assign imm16      = {q.rd, q.shamt, q.funct};
  assign ext_select = q.ext_select;
  assign imm_kind   = q.imm_kind;
  assign illegal    = q.illegal;

`ifdef IMM_DECODE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_count   <= '0;
      stat_illegal <= '0;
    end else if (accept) begin
      if (stat_count != '1) stat_count <= stat_count + 32'd1;
      if (dec_ill && stat_illegal != '1) stat_illegal <= stat_illegal + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboarded bench for imm_decode_stage: handshake, decode, backpressure, flush, reset.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic        ext_select, illegal;
  logic [1:0]  imm_kind;
`ifdef IMM_DECODE_STATS_EN
  logic [31:0] stat_count;
  logic [15:0] stat_illegal;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] word;
    logic        ext;
    logic [1:0]  kind;
    logic        ill;
  } exp_t;

  exp_t q[$];
  logic m_valid = 1'b0;
  int   m_count = 0;
  int   m_ill   = 0;

  imm_decode_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm16(imm16), .ext_select(ext_select), .imm_kind(imm_kind), .illegal(illegal)
`ifdef IMM_DECODE_STATS_EN
    , .stat_count(stat_count), .stat_illegal(stat_illegal)
`endif
  );

  always #5 clk = ~clk;

  // Reference decode written as opcode membership tables.
  function automatic exp_t model(input logic [31:0] w);
    logic [5:0] sgn [8] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h04, 6'h05, 6'h23, 6'h2B};
    logic [5:0] zro [3] = '{6'h0C, 6'h0D, 6'h0E};
    logic [5:0] non [3] = '{6'h00, 6'h02, 6'h03};
    exp_t e;
    e.word = w; e.ext = 1'b0; e.kind = 2'b00; e.ill = 1'b1;
    foreach (sgn[i]) if (w[31:26] == sgn[i]) begin e.kind = 2'b01; e.ill = 1'b0; end
    foreach (zro[i]) if (w[31:26] == zro[i]) begin e.ext = 1'b1; e.kind = 2'b10; e.ill = 1'b0; end
    foreach (non[i]) if (w[31:26] == non[i]) e.ill = 1'b0;
    if (w[31:26] == 6'h0F) begin e.ext = 1'b1; e.kind = 2'b11; e.ill = 1'b0; end
    return e;
  endfunction

  function automatic logic [31:0] mux_out(input logic es, input logic [15:0] im);
    return es ? {16'h0, im} : {{16{im[15]}}, im};
  endfunction

  // Scoreboard model: push on accept, pop on take or flush.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_valid = 1'b0; q.delete(); m_count = 0; m_ill = 0;
    end else begin
      automatic logic rdy  = !m_valid || out_ready;
      automatic logic acc  = in_valid && rdy && !flush;
      automatic logic take = m_valid && (out_ready || flush);
      if (take && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        q.push_back(model(instr));
        m_count++;
        if (model(instr).ill) m_ill++;
      end
      m_valid = flush ? 1'b0 : acc ? 1'b1 : (m_valid && out_ready) ? 1'b0 : m_valid;
    end
  end

  // Compare held output against the scoreboard head on every falling edge.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      checks++;
      if (out_valid !== m_valid) begin
        errors++; $display("FAIL sb_valid got %b want %b @%0t", out_valid, m_valid, $time);
      end
      checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        errors++; $display("FAIL sb_in_ready got %b want %b @%0t", in_ready, !m_valid || out_ready, $time);
      end
      if (m_valid && q.size() > 0) begin
        checks++;
        if ({opcode, rs, rt, rd, shamt, funct} !== q[0].word || imm16 !== q[0].word[15:0] ||
            ext_select !== q[0].ext || imm_kind !== q[0].kind || illegal !== q[0].ill) begin
          errors++;
          $display("FAIL sb_fields got %h/%b/%b/%b want %h/%b/%b/%b @%0t",
                   {opcode, rs, rt, rd, shamt, funct}, ext_select, imm_kind, illegal,
                   q[0].word, q[0].ext, q[0].kind, q[0].ill, $time);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || opcode !== 6'h0 || rs !== 5'h0 || rt !== 5'h0 || imm16 !== 16'h0 ||
        ext_select !== 1'b0 || imm_kind !== 2'b00 || illegal !== 1'b0) begin
      errors++; $display("FAIL reset_state got v=%b op=%h imm=%h es=%b k=%b il=%b want all 0",
                         out_valid, opcode, imm16, ext_select, imm_kind, illegal);
    end
    cyc(); cyc();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_addi();
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h2041FFFF;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || opcode !== 6'h08 || rs !== 5'd2 || rt !== 5'd1 || imm16 !== 16'hFFFF ||
        ext_select !== 1'b0 || imm_kind !== 2'b01) begin
      errors++; $display("FAIL addi got v=%b op=%h rs=%0d rt=%0d imm=%h es=%b k=%b", out_valid, opcode, rs, rt, imm16, ext_select, imm_kind);
    end
    checks++;
    if (mux_out(ext_select, imm16) !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL addi_mux got %h want ffffffff", mux_out(ext_select, imm16));
    end
    cyc();
  endtask

  task automatic test_logical();
    in_valid = 1'b1; instr = 32'h3041FFFF;
    cyc();
    instr = 32'h3C01ABCD;
    checks++;
    if (ext_select !== 1'b1 || imm_kind !== 2'b10 || mux_out(ext_select, imm16) !== 32'h0000FFFF) begin
      errors++; $display("FAIL andi got es=%b k=%b mux=%h want 1/10/0000ffff", ext_select, imm_kind, mux_out(ext_select, imm16));
    end
    cyc();
    in_valid = 1'b0;
    checks++;
    if (opcode !== 6'h0F || ext_select !== 1'b1 || imm_kind !== 2'b11 || imm16 !== 16'hABCD) begin
      errors++; $display("FAIL lui got op=%h es=%b k=%b imm=%h want 0f/1/11/abcd", opcode, ext_select, imm_kind, imm16);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h2041FFFF;
    cyc();
    instr = 32'h3041FFFF;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || opcode !== 6'h08 || imm16 !== 16'hFFFF) begin
        errors++; $display("FAIL hold%0d got rdy=%b v=%b op=%h want 0/1/08", i, in_ready, out_valid, opcode);
      end
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || opcode !== 6'h0C) begin
      errors++; $display("FAIL release got v=%b op=%h want 1/0c", out_valid, opcode);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] s [4] = '{32'h2041FFFF, 32'h34431234, 32'h8C620004, 32'h08000010};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; instr = s[i];
      cyc();
      checks++;
      if (out_valid !== 1'b1 || {opcode, rs, rt, rd, shamt, funct} !== s[i]) begin
        errors++; $display("FAIL b2b%0d got v=%b w=%h want 1/%h", i, out_valid, {opcode, rs, rt, rd, shamt, funct}, s[i]);
      end
    end
    in_valid = 1'b0;
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; instr = 32'h00221820; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_accept got v=%b want 0", out_valid); end
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h2041FFFF;
    cyc();
    in_valid = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_hold got v=%b want 0", out_valid); end
    out_ready = 1'b1;
    cyc();
  endtask

  task automatic test_reset_mid_hold();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h3041FFFF;
    cyc();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || opcode !== 6'h0) begin
      errors++; $display("FAIL reset_async got v=%b op=%h want 0/00", out_valid, opcode);
    end
    out_ready = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; instr = 32'hFC000000;
    cyc();
    in_valid = 1'b1; instr = 32'h2041FFFF;
    checks++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || ext_select !== 1'b0 || imm_kind !== 2'b00) begin
      errors++; $display("FAIL illegal got v=%b il=%b es=%b k=%b want 1/1/0/00", out_valid, illegal, ext_select, imm_kind);
    end
    cyc();
    in_valid = 1'b0;
    cyc();
`ifdef IMM_DECODE_STATS_EN
    checks++;
    if (stat_illegal !== 16'd1 || stat_illegal !== 16'(m_ill)) begin
      errors++; $display("FAIL stat_illegal got %0d want 1", stat_illegal);
    end
    checks++;
    if (stat_count !== 32'd2 || stat_count !== 32'(m_count)) begin
      errors++; $display("FAIL stat_count got %0d want %0d", stat_count, m_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_addi();
    test_logical();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid_hold();
    test_illegal();
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
